// File: rtl/fp_pkg.sv
// Shared FP16 definitions for the half-precision multiplier and divider datapath units.
package fp_pkg;

  localparam int          FP16_EXP_WIDTH  = 5;
  localparam int          FP16_MANT_WIDTH = 10;
  localparam int          FP16_BIAS       = 15;
  localparam logic [15:0] FP16_QNAN       = 16'h7E00;
  localparam logic [15:0] FP16_INF        = 16'h7C00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, PACK} div_state_e;

  // Subnormals classify as zero: the FP16 units flush them on input.
  function automatic fp_class_e fp_classify(input fp16_t x);
    if (x.exp == '0) return FP_ZERO;
    if (x.exp == '1) return (x.frac == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_div_mantissa_core.sv
// Iterative restoring mantissa divider: one quotient bit per clock after start.
module fp_div_mantissa_core
  import fp_pkg::*;
#(
  parameter int MANT_WIDTH = FP16_MANT_WIDTH,
  parameter int QBITS      = MANT_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MANT_WIDTH:0]   dividend,
  input  logic [MANT_WIDTH:0]   divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QBITS-1:0]      quotient,
  output logic                  sticky
);

  localparam int RW = MANT_WIDTH + 2;
  localparam int CW = $clog2(QBITS);

  logic [RW-1:0]    rem, div, rem_next;
  logic [QBITS-1:0] quo;
  logic [CW-1:0]    cnt;
  logic             ge;

  // The partial remainder stays below 2*divisor, so RW bits never overflow.
  always_comb begin
    ge       = (rem >= div);
    rem_next = ge ? ((rem - div) << 1) : (rem << 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem  <= '0;
      div  <= '0;
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= {1'b0, dividend};
      div  <= {1'b0, divisor};
      quo  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_next;
      quo <= {quo[QBITS-2:0], ge};
      cnt <= cnt + 1'b1;
      if (cnt == CW'(QBITS - 1)) busy <= 1'b0;
    end
  end

  assign done     = busy && (cnt == CW'(QBITS - 1));
  assign quotient = quo;
  assign sticky   = (rem != '0);

endmodule

// File: rtl/floating_point_divider.sv
// Fixed-latency FP16 divider (result = a / b). Define FP_DIV_ROUND_NEAREST_EN for
// round-to-nearest-even; otherwise the quotient is truncated toward zero.
module floating_point_divider
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int EXP_WIDTH  = FP16_EXP_WIDTH,
  parameter int MANT_WIDTH = FP16_MANT_WIDTH,
  parameter int QBITS      = MANT_WIDTH + 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ready
);

  localparam int EW2 = EXP_WIDTH + 2;

  fp16_t                  a_f, b_f;
  div_state_e             state, next_state;
  logic                   sign_p0;
  logic signed [EW2-1:0]  exp_p0, exp_p1, exp_fin;
  fp_class_e              cls_a, cls_b;
  logic [MANT_WIDTH:0]    mant_p1;
  logic                   guard_p1, sticky_p1;
  logic                   start, core_busy, core_done, core_sticky;
  logic [QBITS-1:0]       quo;
  logic [MANT_WIDTH+1:0]  rounded;
  logic                   carry;
  logic [MANT_WIDTH-1:0]  frac_fin;
  logic [DATA_WIDTH-1:0]  packed_w;

  function automatic logic [MANT_WIDTH+1:0] round_mant(input logic [MANT_WIDTH:0] mant,
                                                       input logic guard,
                                                       input logic sticky);
`ifdef FP_DIV_ROUND_NEAREST_EN
    return {1'b0, mant} + (MANT_WIDTH+2)'(guard & (sticky | mant[0]));
`else
    logic unused_round;
    unused_round = guard | sticky;
    return {1'b0, mant};
`endif
  endfunction

  assign a_f   = a;
  assign b_f   = b;
  assign start = (state == IDLE) && en;

  fp_div_mantissa_core #(
    .MANT_WIDTH (MANT_WIDTH),
    .QBITS      (QBITS)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend ({1'b1, a_f.frac}),
    .divisor  ({1'b1, b_f.frac}),
    .busy     (core_busy),
    .done     (core_done),
    .quotient (quo),
    .sticky   (core_sticky)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en) next_state = DIVIDE;
      DIVIDE:  if (core_done || !core_busy) next_state = NORM;
      NORM:    next_state = PACK;
      PACK:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stage p0: operand capture; p1: normalised mantissa with guard and sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_p0   <= 1'b0;
      exp_p0    <= '0;
      cls_a     <= FP_ZERO;
      cls_b     <= FP_ZERO;
      exp_p1    <= '0;
      mant_p1   <= '0;
      guard_p1  <= 1'b0;
      sticky_p1 <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (en) begin
          sign_p0 <= a_f.sign ^ b_f.sign;
          exp_p0  <= $signed(EW2'(a_f.exp)) - $signed(EW2'(b_f.exp)) + $signed(EW2'(FP16_BIAS));
          cls_a   <= fp_classify(a_f);
          cls_b   <= fp_classify(b_f);
        end
        NORM: begin
          if (!quo[QBITS-1]) begin
            mant_p1   <= quo[QBITS-2:1];
            guard_p1  <= quo[0];
            sticky_p1 <= core_sticky;
            exp_p1    <= exp_p0 - $signed(EW2'(1));
          end else begin
            mant_p1   <= quo[QBITS-1:2];
            guard_p1  <= quo[1];
            sticky_p1 <= core_sticky | quo[0];
            exp_p1    <= exp_p0;
          end
        end
        PACK: begin
          result <= packed_w;
          ready  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Specials override the arithmetic path so every class takes the same latency.
  always_comb begin
    rounded  = round_mant(mant_p1, guard_p1, sticky_p1);
    carry    = rounded[MANT_WIDTH+1];
    frac_fin = carry ? rounded[MANT_WIDTH:1] : rounded[MANT_WIDTH-1:0];
    exp_fin  = exp_p1 + (carry ? $signed(EW2'(1)) : $signed(EW2'(0)));
    packed_w = {sign_p0, exp_fin[EXP_WIDTH-1:0], frac_fin};
    if (exp_fin >= $signed(EW2'((1 << EXP_WIDTH) - 1)))
      packed_w = {sign_p0, FP16_INF[DATA_WIDTH-2:0]};
    else if (exp_fin <= $signed(EW2'(0)))
      packed_w = {sign_p0, {(DATA_WIDTH-1){1'b0}}};
    if (cls_a == FP_NAN || cls_b == FP_NAN ||
        (cls_a == FP_ZERO && cls_b == FP_ZERO) ||
        (cls_a == FP_INF && cls_b == FP_INF))
      packed_w = FP16_QNAN;
    else if (cls_b == FP_ZERO || cls_a == FP_INF)
      packed_w = {sign_p0, FP16_INF[DATA_WIDTH-2:0]};
    else if (cls_a == FP_ZERO || cls_b == FP_INF)
      packed_w = {sign_p0, {(DATA_WIDTH-1){1'b0}}};
  end

endmodule

// File: tb/tb_floating_point_divider.sv
// Scoreboard bench for floating_point_divider: results and fixed latency of 15 edges.
module tb_floating_point_divider;

  typedef struct {
    string       name;
    logic [15:0] res;
    int          start;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] a, b;
  logic [15:0] result;
  logic        ready;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_ready = 0;
  logic prev_ready = 1'b0;
  exp_t sb[$];

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam logic [15:0] EXP_5_3 = 16'h3EAB;
`else
  localparam logic [15:0] EXP_5_3 = 16'h3EAA;
`endif

  floating_point_divider dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .a      (a),
    .b      (b),
    .result (result),
    .ready  (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (prev_ready) check_val("ready_width", 32'(ready), 32'd0);
    prev_ready <= ready;
    if (ready) begin
      n_ready <= n_ready + 1;
      if (sb.size() == 0) begin
        check_val("spurious_ready", 32'(ready), 32'd0);
      end else begin
        e = sb.pop_front();
        check_val({e.name, "_result"}, 32'(result), 32'(e.res));
        check_val({e.name, "_latency"}, 32'(cyc - e.start), 32'd15);
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val({name, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] want);
    @(negedge clk);
    a  = x;
    b  = y;
    en = 1'b1;
    sb.push_back('{name, want, cyc + 1});
    @(negedge clk);
    en = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int r0;
    reset = 1'b1;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_val("reset_result", 32'(result), 32'd0);
    check_val("reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;

    run_op("div_6_2", 16'h4600, 16'h4000, 16'h4200);
    run_op("div_5_3", 16'h4500, 16'h4200, EXP_5_3);
    run_op("one_by_zero", 16'h3C00, 16'h0000, 16'h7C00);
    run_op("zero_by_zero", 16'h0000, 16'h0000, 16'h7E00);
    run_op("neg2_by_2", 16'hC000, 16'h4000, 16'hBC00);
    run_op("inf_by_inf", 16'h7C00, 16'h7C00, 16'h7E00);
    run_op("overflow", 16'h7BFF, 16'h0400, 16'h7C00);
    run_op("underflow", 16'h0400, 16'h7BFF, 16'h0000);
    run_op("nan_by_one", 16'h7E01, 16'h3C00, 16'h7E00);
    run_op("one_by_neg_inf", 16'h3C00, 16'hFC00, 16'h8000);

    // Abort: reset sampled at edge 5 of an operation.
    @(negedge clk);
    a  = 16'h4600;
    b  = 16'h4000;
    en = 1'b1;
    s  = cyc + 1;
    @(negedge clk);
    en = 1'b0;
    while (cyc < s + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    r0 = n_ready;
    repeat (20) @(negedge clk);
    check_val("abort_ready_count", 32'(n_ready - r0), 32'd0);
    check_val("abort_result", 32'(result), 32'd0);
    run_op("after_abort", 16'h4600, 16'h4000, 16'h4200);

    // en held high, operands changed before edge 3; next start lands on edge 16.
    @(negedge clk);
    a  = 16'h4600;
    b  = 16'h4000;
    en = 1'b1;
    s  = cyc + 1;
    sb.push_back('{"held_first", 16'h4200, s});
    while (cyc < s + 2) @(negedge clk);
    a = 16'h4500;
    b = 16'h4200;
    while (cyc < s + 15) @(negedge clk);
    sb.push_back('{"held_second", EXP_5_3, s + 16});
    @(negedge clk);
    en = 1'b0;
    wait_drain("held");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/floating_point_divider.md
Name: floating_point_divider

Overview:
- Iterative IEEE-754 half-precision divider: result = a / b.
- Inverse companion of the FP16 multiplier; shares its operand and handshake interface (clk, reset, en, a, b, result, ready) so the datapath can use either unit interchangeably.
- Multi-cycle restoring division on the mantissas, one quotient bit per clock, with fixed latency for every input class.

Parameters:
- DATA_WIDTH, 16, total float width; only 16 is supported.
- EXP_WIDTH, 5, exponent field width.
- MANT_WIDTH, 10, stored fraction width.
- QBITS, MANT_WIDTH+3, quotient bits produced: hidden bit + fraction + normalise bit + guard.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  start request; sampled only in IDLE.
- a  input  DATA_WIDTH  dividend (FP16).
- b  input  DATA_WIDTH  divisor (FP16).
- result  output  DATA_WIDTH  quotient; holds its value until the next completion.
- ready  output  1  one-cycle pulse; result is valid in the same cycle.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, result=16'h0000, ready=0, all internal registers cleared.
  - Reset mid-operation aborts the operation: no ready pulse, result=0.
- FSM states: IDLE, DIVIDE, NORM, PACK.
  - IDLE: ready=0. If en=1 at edge E0:
    - latch sign = a[15]^b[15];
    - latch exponent difference e = ea - eb + 15, as a (EXP_WIDTH+2)-bit signed value;
    - latch mantissas {1,fa} and {1,fb};
    - classify both operands (zero/subnormal, inf, NaN, normal);
    - go to DIVIDE with count=0.
  - DIVIDE: one restoring step per edge. rem = rem - divisor; if non-negative, qbit=1; else restore and qbit=0. Leaves after QBITS=13 edges (E1..E13).
  - NORM (E14): if quotient MSB=0, shift left by 1 and decrement e. Sticky = (remainder != 0).
  - PACK (E15): apply rounding and specials; register result; ready=1; go to IDLE.
- Latency and throughput:
  - ready is high in the cycle after E15, i.e. 15 edges after en is sampled.
  - en seen at E16 starts the next operation: throughput is one operation per 16 cycles.
  - en is ignored outside IDLE; operands are not re-sampled mid-operation.
- Subnormal inputs are treated as zero; subnormal outputs flush to signed zero.
- Exponent rules after normalisation and rounding:
  - e >= 31: signed infinity {sign,5'h1F,10'h0}.
  - e <= 0: signed zero.
  - A rounding carry out of the mantissa increments e before this overflow check.
- Specials are resolved in PACK, so latency stays fixed:
  - Either input NaN, 0/0, or inf/inf: canonical qNaN 16'h7E00, sign ignored.
  - nonzero/0: signed infinity.
  - inf/finite: signed infinity.
  - 0/nonzero: signed zero.
  - finite/inf: signed zero.

Optional Feature:
- Macro: FP_DIV_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even using guard and sticky; increment when guard & (sticky | lsb).
- Undefined: truncation (round toward zero); guard and sticky are discarded.
- Latency is identical in both builds.

Decomposition:
- Shared package fp_pkg holds:
  - constants FP16_EXP_WIDTH, FP16_MANT_WIDTH, FP16_BIAS=15, FP16_QNAN=16'h7E00, FP16_INF=16'h7C00;
  - typedef fp16_t, a packed struct {sign, exp[4:0], frac[9:0]};
  - typedef fp_class_e {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - function fp_classify.
  - The multiplier migrates to the same package.
- Sub-module fp_div_mantissa_core: iterative restoring divider with start/busy/done, producing quotient[QBITS-1:0] and sticky.
- The top level owns the FSM, exponent logic, specials and packing.

Test Plan:
- a=16'h4600 (6.0), b=16'h4000 (2.0), en pulse -> after 15 edges ready=1 for one cycle, result=16'h4200 (3.0).
- a=16'h4500 (5.0), b=16'h4200 (3.0) -> result=16'h3EAB with FP_DIV_ROUND_NEAREST_EN, 16'h3EAA without.
- Specials, expected results in order:
  - 16'h3C00 / 16'h0000 -> 16'h7C00;
  - 16'h0000 / 16'h0000 -> 16'h7E00;
  - 16'hC000 / 16'h4000 -> 16'hBC00;
  - 16'h7C00 / 16'h7C00 -> 16'h7E00.
  - Each completes with latency 15.
- Overflow and underflow:
  - 16'h7BFF / 16'h0400 -> 16'h7C00;
  - 16'h0400 / 16'h7BFF -> 16'h0000.
- Reset mid-operation: start 16'h4600/16'h4000, assert reset at edge 5 -> no ready pulse, result=0. A subsequent start completes normally.
- en held high with operands changed at edge 3 -> first result uses the operands latched at E0. The next operation starts at E16, with its ready pulse 16 cycles after the first.
